pcie_pipe_skp_sched: RTL and testbench

- Transmit-side ordered-set scheduler for the x1 PIPE symbol lane driven by the PCIe VHost.
- Passes upstream 8b symbols (data + K flag) to the PIPE TX lane.
- Every SKP_INTERVAL symbol times it inserts a SKP ordered set (COM followed by NUM_SKP SKP symbols), only at legal boundaries: idle gaps or the start of a packet.
- Upstream is stalled with a valid/ready handshake while the ordered set is sent.

---
 rtl/pcie_pipe_sym_pkg.sv | 26 ++
 rtl/pcie_pipe_skp_sched.sv | 121 ++++++++++++
 tb/tb_pcie_pipe_skp_sched.sv | 320 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/pcie_pipe_sym_pkg.sv
// Shared PIPE 8b symbol definitions for the TX SKP scheduler and the RX elastic buffer.
package pcie_pipe_sym_pkg;

  localparam logic [7:0] SYM_COM = 8'hBC;
  localparam logic [7:0] SYM_SKP = 8'h1C;
  localparam logic [7:0] SYM_STP = 8'hFB;
  localparam logic [7:0] SYM_SDP = 8'h5C;
  localparam logic [7:0] SYM_END = 8'hFD;
  localparam logic [7:0] SYM_IDL = 8'h00;

  typedef enum logic {
    PASS = 1'b0,
    SKP  = 1'b1
  } skp_state_e;

  typedef struct packed {
    logic       k;
    logic [7:0] data;
  } sym_t;

  // A packet boundary where an ordered set may be slipped in ahead of the packet.
  function automatic logic is_pkt_start(sym_t s);
    return s.k && (s.data == SYM_STP || s.data == SYM_SDP);
  endfunction

endpackage

// File: rtl/pcie_pipe_skp_sched.sv
// x1 PIPE TX symbol path with periodic/forced SKP ordered-set insertion at
// idle gaps or packet starts; upstream is stalled while the OS goes out.
module pcie_pipe_skp_sched
  import pcie_pipe_sym_pkg::*;
#(
  parameter int SKP_INTERVAL = 1180,
  parameter int NUM_SKP      = 3,
  parameter int MAX_DEFER    = 4608,
  parameter int CNT_WIDTH    = 13
) (
  input  logic       pclk,
  input  logic       nreset,
  input  logic       Enable,
  input  logic       ForceSkp,
  input  logic [7:0] InData,
  input  logic       InDataK,
  input  logic       InValid,
  output logic       InReady,
  output logic [7:0] TxData,
  output logic       TxDataK,
  output logic       SkpActive,
  output logic       SkpOverdue
);

  localparam logic [CNT_WIDTH-1:0] CNT_ONE   = CNT_WIDTH'(1);
  localparam logic [CNT_WIDTH-1:0] CNT_MAX   = '1;
  localparam logic [CNT_WIDTH-1:0] INT_LAST  = CNT_WIDTH'(SKP_INTERVAL - 1);
  localparam logic [CNT_WIDTH-1:0] DEFER_LIM = CNT_WIDTH'(MAX_DEFER);
  localparam logic [2:0]           SKP_LOAD  = 3'(NUM_SKP);

  skp_state_e           state_q, state_d;
  logic [2:0]           skp_cnt_q, skp_cnt_d;
  logic [CNT_WIDTH-1:0] int_cnt_q, int_cnt_d;
  logic [CNT_WIDTH-1:0] defer_q, defer_d;
  logic                 pend_q, pend_d;
  logic                 ovd_q, ovd_d;
  logic                 act_q, act_d;
  sym_t                 tx_q, tx_d;
  sym_t                 in_sym;
  logic                 insert_ok;
  logic                 pend_set;

  assign in_sym    = '{k: InDataK, data: InData};
  assign insert_ok = pend_q && (state_q == PASS) && (!InValid || is_pkt_start(in_sym));
  assign InReady   = (state_q == PASS) && !insert_ok && nreset;

  assign TxData     = tx_q.data;
  assign TxDataK    = tx_q.k;
  assign SkpActive  = act_q;
  assign SkpOverdue = ovd_q;

  // Symbol select and PASS/SKP sequencing; COM is chosen on the insertion cycle.
  always_comb begin
    state_d   = state_q;
    skp_cnt_d = skp_cnt_q;
    tx_d      = '{k: 1'b0, data: SYM_IDL};
    act_d     = 1'b0;
    case (state_q)
      PASS: begin
        if (insert_ok) begin
          tx_d      = '{k: 1'b1, data: SYM_COM};
          act_d     = 1'b1;
          skp_cnt_d = SKP_LOAD;
          state_d   = SKP;
        end else if (InValid) begin
          tx_d = in_sym;
        end
      end
      SKP: begin
        tx_d      = '{k: 1'b1, data: SYM_SKP};
        act_d     = 1'b1;
        skp_cnt_d = skp_cnt_q - 3'd1;
        if (skp_cnt_q == 3'd1) state_d = PASS;
      end
      default: state_d = PASS;
    endcase
  end

  // Interval, pending-request and defer bookkeeping. A new request in the COM
  // cycle wins over the clear, so a ForceSkp there is not lost.
  always_comb begin
    int_cnt_d = int_cnt_q;
    if (insert_ok || !Enable)                        int_cnt_d = '0;
    else if (state_q == PASS && int_cnt_q != CNT_MAX) int_cnt_d = int_cnt_q + CNT_ONE;

    pend_set = ForceSkp || (Enable && int_cnt_q == INT_LAST);
    if (pend_set)                  pend_d = 1'b1;
    else if (!Enable || insert_ok) pend_d = 1'b0;
    else                           pend_d = pend_q;

    defer_d = '0;
    if (pend_q && pend_d && !insert_ok)
      defer_d = (defer_q == CNT_MAX) ? defer_q : defer_q + CNT_ONE;

    ovd_d = ovd_q || (defer_d == DEFER_LIM);
  end

  // State and output registers; reset abandons any OS in progress.
  always_ff @(posedge pclk) begin
    if (!nreset) begin
      state_q   <= PASS;
      skp_cnt_q <= '0;
      int_cnt_q <= '0;
      defer_q   <= '0;
      pend_q    <= 1'b0;
      ovd_q     <= 1'b0;
      act_q     <= 1'b0;
      tx_q      <= '{k: 1'b0, data: SYM_IDL};
    end else begin
      state_q   <= state_d;
      skp_cnt_q <= skp_cnt_d;
      int_cnt_q <= int_cnt_d;
      defer_q   <= defer_d;
      pend_q    <= pend_d;
      ovd_q     <= ovd_d;
      act_q     <= act_d;
      tx_q      <= tx_d;
    end
  end

endmodule

// File: tb/tb_pcie_pipe_skp_sched.sv
// Bench for pcie_pipe_skp_sched: per-scenario tasks against a per-cycle output
// trace, plus a scoreboard of accepted upstream symbols vs. TX data symbols.
module tb_pcie_pipe_skp_sched;
  import pcie_pipe_sym_pkg::*;

  localparam int SKP_INTERVAL = 16;
  localparam int NUM_SKP      = 3;
  localparam int MAX_DEFER    = 36;
  localparam int CNT_WIDTH    = 13;

  logic       pclk = 1'b0;
  logic       nreset = 1'b0;
  logic       Enable = 1'b0;
  logic       ForceSkp = 1'b0;
  logic [7:0] InData = 8'h00;
  logic       InDataK = 1'b0;
  logic       InValid = 1'b0;
  logic       InReady;
  logic [7:0] TxData;
  logic       TxDataK;
  logic       SkpActive;
  logic       SkpOverdue;

  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  sym_t acc_q[$];
  // trace entry: {SkpOverdue, SkpActive, TxDataK, TxData} sampled during cycle index
  logic [10:0] trc [128];
  logic        rdy [128];
  logic        last_acc = 1'b0;
  logic        prev_stall = 1'b0;
  sym_t        prev_sym;

  pcie_pipe_skp_sched #(
    .SKP_INTERVAL(SKP_INTERVAL), .NUM_SKP(NUM_SKP),
    .MAX_DEFER(MAX_DEFER), .CNT_WIDTH(CNT_WIDTH)
  ) dut (
    .pclk(pclk), .nreset(nreset), .Enable(Enable), .ForceSkp(ForceSkp),
    .InData(InData), .InDataK(InDataK), .InValid(InValid), .InReady(InReady),
    .TxData(TxData), .TxDataK(TxDataK), .SkpActive(SkpActive), .SkpOverdue(SkpOverdue)
  );

  always #5 pclk = ~pclk;

  // cycle index since the last reset edge
  always @(posedge pclk) cyc <= nreset ? cyc + 1 : 0;

  // one clock: sample/score at the negedge, then land 1 time unit after the next posedge
  task automatic tick();
    sym_t got, exp;
    @(negedge pclk);
    if (cyc < 128) begin
      trc[cyc] = {SkpOverdue, SkpActive, TxDataK, TxData};
      rdy[cyc] = InReady;
    end
    if (nreset) begin
      got = {TxDataK, TxData};
      if (SkpActive) begin
        checks++;
        if (!(TxDataK && (TxData == SYM_COM || TxData == SYM_SKP))) begin
          errors++; $display("FAIL os_symbol cyc=%0d got k=%b data=%h", cyc, TxDataK, TxData);
        end
      end else if (TxDataK || TxData != SYM_IDL) begin
        checks++;
        if (acc_q.size() == 0) begin
          errors++; $display("FAIL sb_extra cyc=%0d got %h want nothing", cyc, got);
        end else begin
          exp = acc_q.pop_front();
          if (got !== exp) begin
            errors++; $display("FAIL sb_data cyc=%0d got %h want %h", cyc, got, exp);
          end
        end
      end
      if (prev_stall) begin
        checks++;
        if (!(InValid && {InDataK, InData} == prev_sym)) begin
          errors++; $display("FAIL upstream_hold cyc=%0d got %h want %h", cyc, {InDataK, InData}, prev_sym);
        end
      end
      last_acc = InValid && InReady;
      if (last_acc) acc_q.push_back({InDataK, InData});
      prev_stall = InValid && !InReady;
      prev_sym   = {InDataK, InData};
    end else begin
      last_acc   = 1'b0;
      prev_stall = 1'b0;
    end
    @(posedge pclk); #1;
  endtask

  // leaves the bench in cycle 0 of a fresh run
  task automatic do_reset(input logic en);
    nreset = 1'b0; ForceSkp = 1'b0; InValid = 1'b0; InDataK = 1'b0; InData = 8'h00;
    Enable = en;
    tick(); tick();
    nreset = 1'b1;
  endtask

  // STP/SDP + random data + END; n = clocks consumed including stalls
  task automatic send_pkt(input int len, input logic [7:0] first, output int n);
    n = 0;
    for (int i = 0; i < len; i++) begin
      int w;
      w = 0;
      InValid = 1'b1;
      if (i == 0) begin
        InDataK = 1'b1; InData = first;
      end else if (i == len - 1) begin
        InDataK = 1'b1; InData = SYM_END;
      end else begin
        InDataK = 1'b0; InData = 8'($urandom_range(255, 1));
      end
      do begin tick(); n++; w++; end while (!last_acc && w < 50);
      if (!last_acc) begin
        checks++; errors++;
        $display("FAIL accept_timeout sym=%0d got no accept want accept within 50", i);
        InValid = 1'b0;
        return;
      end
    end
    InValid = 1'b0; InDataK = 1'b0; InData = 8'h00;
  endtask

  task automatic test_reset();
    nreset = 1'b0; Enable = 1'b1; InValid = 1'b1; InDataK = 1'b1; InData = SYM_STP;
    tick(); tick();
    checks++;
    if ({TxDataK, TxData, SkpActive, SkpOverdue} !== 11'h000) begin
      errors++; $display("FAIL reset_out got k=%b d=%h a=%b o=%b want all 0", TxDataK, TxData, SkpActive, SkpOverdue);
    end
    checks++;
    if (InReady !== 1'b0) begin
      errors++; $display("FAIL reset_ready got %b want 0", InReady);
    end
    InValid = 1'b0; InDataK = 1'b0; InData = 8'h00;
  endtask

  task automatic test_periodic();
    do_reset(1'b1);
    repeat (60) tick();
    for (int j = 1; j <= 16; j++) begin
      checks++;
      if (trc[j][9:0] !== 10'h000) begin
        errors++; $display("FAIL per_idle j=%0d got %h want 000", j, trc[j][9:0]);
      end
    end
    for (int j = 17; j <= 57; j += 20) begin
      checks++;
      if (trc[j][9:0] !== {2'b11, SYM_COM}) begin
        errors++; $display("FAIL per_com j=%0d got %h want %h", j, trc[j][9:0], {2'b11, SYM_COM});
      end
    end
    for (int j = 18; j <= 20; j++) begin
      checks++;
      if (trc[j][9:0] !== {2'b11, SYM_SKP}) begin
        errors++; $display("FAIL per_skp j=%0d got %h want %h", j, trc[j][9:0], {2'b11, SYM_SKP});
      end
    end
    checks++;
    if (trc[21][9:0] !== 10'h000 || trc[36][9:0] !== 10'h000) begin
      errors++; $display("FAIL per_gap got %h/%h want 000/000", trc[21][9:0], trc[36][9:0]);
    end
    checks++;
    if ({rdy[15], rdy[16], rdy[17], rdy[18], rdy[19], rdy[20]} !== 6'b100001) begin
      errors++; $display("FAIL per_ready got %b want 100001",
                         {rdy[15], rdy[16], rdy[17], rdy[18], rdy[19], rdy[20]});
    end
  endtask

  task automatic test_no_mid_insert();
    int n;
    do_reset(1'b1);
    repeat (11) tick();
    send_pkt(40, SYM_STP, n);
    checks++;
    if (n != 40) begin
      errors++; $display("FAIL mid_pkt_cycles got %0d want 40", n);
    end
    repeat (10) tick();
    for (int j = 12; j <= 51; j++) begin
      checks++;
      if (trc[j][9] !== 1'b0) begin
        errors++; $display("FAIL mid_pkt_os j=%0d got act=%b want 0", j, trc[j][9]);
      end
    end
    checks++;
    if (trc[52][9:0] !== {2'b11, SYM_COM}) begin
      errors++; $display("FAIL mid_com j=52 got %h want %h", trc[52][9:0], {2'b11, SYM_COM});
    end
    for (int j = 53; j <= 55; j++) begin
      checks++;
      if (trc[j][9:0] !== {2'b11, SYM_SKP}) begin
        errors++; $display("FAIL mid_skp j=%0d got %h want %h", j, trc[j][9:0], {2'b11, SYM_SKP});
      end
    end
    for (int j = 1; j <= 60; j++) begin
      checks++;
      if (trc[j][10] !== 1'b0) begin
        errors++; $display("FAIL mid_overdue j=%0d got %b want 0", j, trc[j][10]);
      end
    end
  endtask

  task automatic test_back_to_back();
    int na, nb;
    do_reset(1'b1);
    repeat (5) tick();
    send_pkt(11, SYM_STP, na);
    send_pkt(6, SYM_SDP, nb);
    repeat (4) tick();
    checks++;
    if (na != 11 || nb != 10) begin
      errors++; $display("FAIL b2b_cycles got %0d/%0d want 11/10", na, nb);
    end
    checks++;
    if ({rdy[16], rdy[17], rdy[18], rdy[19], rdy[20]} !== 5'b00001) begin
      errors++; $display("FAIL b2b_ready got %b want 00001", {rdy[16], rdy[17], rdy[18], rdy[19], rdy[20]});
    end
    checks++;
    if (trc[17][9:0] !== {2'b11, SYM_COM}) begin
      errors++; $display("FAIL b2b_com got %h want %h", trc[17][9:0], {2'b11, SYM_COM});
    end
    for (int j = 18; j <= 20; j++) begin
      checks++;
      if (trc[j][9:0] !== {2'b11, SYM_SKP}) begin
        errors++; $display("FAIL b2b_skp j=%0d got %h want %h", j, trc[j][9:0], {2'b11, SYM_SKP});
      end
    end
    checks++;
    if (trc[21][9:0] !== {2'b01, SYM_SDP}) begin
      errors++; $display("FAIL b2b_held_start got %h want %h", trc[21][9:0], {2'b01, SYM_SDP});
    end
  endtask

  task automatic test_force();
    do_reset(1'b0);
    repeat (3) tick();
    ForceSkp = 1'b1; tick(); ForceSkp = 1'b0;
    repeat (3) tick();
    ForceSkp = 1'b1; tick(); ForceSkp = 1'b0;
    repeat (25) tick();
    for (int j = 1; j <= 32; j++) begin
      logic [9:0] want;
      if (j == 5 || j == 9)                   want = {2'b11, SYM_COM};
      else if ((j >= 6 && j <= 8) || (j >= 10 && j <= 12)) want = {2'b11, SYM_SKP};
      else                                    want = 10'h000;
      checks++;
      if (trc[j][9:0] !== want) begin
        errors++; $display("FAIL force_seq j=%0d got %h want %h", j, trc[j][9:0], want);
      end
    end
  endtask

  task automatic test_overdue();
    int n;
    do_reset(1'b1);
    repeat (11) tick();
    send_pkt(60, SYM_STP, n);
    repeat (12) tick();
    checks++;
    if (n != 60) begin
      errors++; $display("FAIL ovd_cycles got %0d want 60", n);
    end
    checks++;
    if ({trc[40][10], trc[51][10], trc[52][10]} !== 3'b001) begin
      errors++; $display("FAIL ovd_rise got %b want 001", {trc[40][10], trc[51][10], trc[52][10]});
    end
    checks++;
    if (trc[72][9:0] !== {2'b11, SYM_COM}) begin
      errors++; $display("FAIL ovd_com j=72 got %h want %h", trc[72][9:0], {2'b11, SYM_COM});
    end
    for (int j = 73; j <= 82; j++) begin
      checks++;
      if (trc[j][10] !== 1'b1) begin
        errors++; $display("FAIL ovd_sticky j=%0d got %b want 1", j, trc[j][10]);
      end
    end
  endtask

  task automatic test_reset_mid_os();
    do_reset(1'b1);
    repeat (18) tick();
    nreset = 1'b0;
    tick();
    checks++;
    if ({TxDataK, TxData, SkpActive, InReady} !== 11'h000) begin
      errors++; $display("FAIL mid_os_reset got k=%b d=%h a=%b r=%b want all 0", TxDataK, TxData, SkpActive, InReady);
    end
    nreset = 1'b1;
    repeat (20) tick();
    for (int j = 1; j <= 16; j++) begin
      checks++;
      if (trc[j][9:0] !== 10'h000) begin
        errors++; $display("FAIL rst_resume j=%0d got %h want 000", j, trc[j][9:0]);
      end
    end
    checks++;
    if (trc[17][9:0] !== {2'b11, SYM_COM}) begin
      errors++; $display("FAIL rst_com j=17 got %h want %h", trc[17][9:0], {2'b11, SYM_COM});
    end
  endtask

  initial begin
    test_reset();
    test_periodic();
    test_no_mid_insert();
    test_back_to_back();
    test_force();
    test_overdue();
    test_reset_mid_os();
    checks++;
    if (acc_q.size() != 0) begin
      errors++; $display("FAIL sb_leftover got %0d want 0", acc_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
